// File: rtl/jesd204b_rx_sync_ctrl.sv
// JESD204B receive link bring-up controller: drives SYNC~ through CGS, LMFC-aligned
// release, ILAS supervision and data-phase error monitoring with resync requests.
module jesd204b_rx_sync_ctrl #(
  parameter int unsigned LANES             = 1,
  parameter int unsigned K_THRESH          = 4,
  parameter int unsigned SYNC_DELAY_LMFC   = 1,
  parameter int unsigned ILAS_TIMEOUT_LMFC = 8,
  parameter int unsigned ERR_THRESH        = 4
) (
  input  logic             dclk,
  input  logic             rst_n,
  input  logic             i_link_en,
  input  logic             i_sysref_done,
  input  logic             i_lmfc,
  input  logic [LANES-1:0] i_lane_k_det,
  input  logic [LANES-1:0] i_lane_ila_start,
  input  logic [LANES-1:0] i_lane_err,
  output logic             o_sync_n,
  output logic [2:0]       o_state,
  output logic [LANES-1:0] o_lane_lock,
  output logic             o_ilas_done,
  output logic             o_link_up,
  output logic [7:0]       o_resync_cnt
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] K_MAX   = CW'(K_THRESH);
  localparam logic [CW-1:0] SYNC_MAX = CW'(SYNC_DELAY_LMFC);
  localparam logic [CW-1:0] TMO_MAX = CW'(ILAS_TIMEOUT_LMFC);
  localparam logic [CW-1:0] ERR_MAX = CW'(ERR_THRESH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CGS  = 3'd1,
    S_WAIT = 3'd2,
    S_ILAS = 3'd3,
    S_DATA = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic            lmfc_q, lmfc_edge, sysref_seen;
  logic [CW-1:0]   k_cnt [LANES];
  logic [CW-1:0]   k_nx  [LANES];
  logic [LANES-1:0] lane_lock, ila_seen;
  logic [CW-1:0]   wait_cnt, tmo_cnt, err_cnt, err_nx, resync_cnt;
  logic            err_any, clear_all, resync_ev;
  logic            sync_n_d, link_up_d, ilas_done_d;

  assign lmfc_edge = i_lmfc & ~lmfc_q;
  assign err_any   = |i_lane_err;
  // an LMFC edge opens a fresh error window, seeded by an error in the same cycle
  assign err_nx    = lmfc_edge ? CW'(err_any) : err_cnt + CW'(err_any);

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      k_nx[i] = '0;
      if (i_lane_k_det[i]) k_nx[i] = (k_cnt[i] == K_MAX) ? K_MAX : k_cnt[i] + CW'(1);
    end
  end

  // state register and registered outputs
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      o_sync_n    <= 1'b0;
      o_link_up   <= 1'b0;
      o_ilas_done <= 1'b0;
    end else begin
      state       <= state_nx;
      o_sync_n    <= sync_n_d;
      o_link_up   <= link_up_d;
      o_ilas_done <= ilas_done_d;
    end
  end

  // next-state logic; link disable overrides everything
  always_comb begin
    state_nx = state;
    if (!i_link_en) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (sysref_seen) state_nx = S_CGS;
        S_CGS:  if (&lane_lock) state_nx = S_WAIT;
        S_WAIT: begin
          if (!(&i_lane_k_det))                                  state_nx = S_CGS;
          else if (lmfc_edge && (wait_cnt + CW'(1) == SYNC_MAX)) state_nx = S_ILAS;
        end
        S_ILAS: begin
          if (&ila_seen)                                        state_nx = S_DATA;
          else if (lmfc_edge && (tmo_cnt + CW'(1) == TMO_MAX))  state_nx = S_CGS;
        end
        S_DATA: if (err_nx == ERR_MAX) state_nx = S_CGS;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sync_n_d    = 1'b0;
    link_up_d   = 1'b0;
    ilas_done_d = 1'b0;
    sync_n_d    = (state_nx == S_ILAS) || (state_nx == S_DATA);
    link_up_d   = (state_nx == S_DATA);
    ilas_done_d = (state == S_ILAS) && (state_nx == S_DATA);
  end

  assign clear_all = (state_nx == S_IDLE) || ((state_nx == S_CGS) && (state != S_CGS));
  assign resync_ev = ((state == S_ILAS) || (state == S_DATA)) && (state_nx == S_CGS);

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      lmfc_q      <= 1'b0;
      sysref_seen <= 1'b0;
      lane_lock   <= '0;
      ila_seen    <= '0;
      wait_cnt    <= '0;
      tmo_cnt     <= '0;
      err_cnt     <= '0;
      resync_cnt  <= '0;
      for (int i = 0; i < LANES; i++) k_cnt[i] <= '0;
    end else begin
      lmfc_q      <= i_lmfc;
      sysref_seen <= i_link_en & (sysref_seen | i_sysref_done);
      if (resync_ev && (resync_cnt != 8'hFF)) resync_cnt <= resync_cnt + 8'd1;
      if (clear_all) begin
        lane_lock <= '0;
        ila_seen  <= '0;
        wait_cnt  <= '0;
        tmo_cnt   <= '0;
        err_cnt   <= '0;
        for (int i = 0; i < LANES; i++) k_cnt[i] <= '0;
      end else begin
        case (state)
          S_CGS: begin
            for (int i = 0; i < LANES; i++) begin
              k_cnt[i]     <= k_nx[i];
              lane_lock[i] <= (k_nx[i] == K_MAX);
            end
          end
          S_WAIT: if (lmfc_edge) wait_cnt <= wait_cnt + CW'(1);
          S_ILAS: begin
            ila_seen <= ila_seen | i_lane_ila_start;
            if (lmfc_edge) tmo_cnt <= tmo_cnt + CW'(1);
          end
          S_DATA:  err_cnt <= err_nx;
          default: ;
        endcase
      end
    end
  end

  assign o_state      = state;
  assign o_lane_lock  = lane_lock;
  assign o_resync_cnt = resync_cnt;

endmodule

// File: tb/tb_jesd204b_rx_sync_ctrl.sv
// Bench for jesd204b_rx_sync_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural model.
module tb_jesd204b_rx_sync_ctrl;

  localparam int LANES = 2;
  localparam int K_THRESH = 4;
  localparam int SYNC_DELAY_LMFC = 1;
  localparam int ILAS_TIMEOUT_LMFC = 2;
  localparam int ERR_THRESH = 4;
  localparam int RAND_CYCLES = 3000;
  localparam int NVEC = 24;

  typedef struct packed {
    logic             link_en;
    logic             sysref;
    logic             lmfc;
    logic [LANES-1:0] k;
    logic [LANES-1:0] ila;
    logic [LANES-1:0] err;
  } in_t;

  typedef struct packed {
    in_t              in;
    logic [2:0]       st;
    logic             sync_n;
    logic             link_up;
    logic             done;
    logic [LANES-1:0] lock;
    logic [7:0]       resync;
  } vec_t;

  logic             dclk, rst_n, i_link_en, i_sysref_done, i_lmfc;
  logic [LANES-1:0] i_lane_k_det, i_lane_ila_start, i_lane_err;
  logic             o_sync_n, o_ilas_done, o_link_up;
  logic [2:0]       o_state;
  logic [LANES-1:0] o_lane_lock;
  logic [7:0]       o_resync_cnt;

  int n_checks = 0;
  int n_fail = 0;

  jesd204b_rx_sync_ctrl #(
    .LANES(LANES), .K_THRESH(K_THRESH), .SYNC_DELAY_LMFC(SYNC_DELAY_LMFC),
    .ILAS_TIMEOUT_LMFC(ILAS_TIMEOUT_LMFC), .ERR_THRESH(ERR_THRESH)
  ) dut (
    .dclk(dclk), .rst_n(rst_n), .i_link_en(i_link_en), .i_sysref_done(i_sysref_done),
    .i_lmfc(i_lmfc), .i_lane_k_det(i_lane_k_det), .i_lane_ila_start(i_lane_ila_start),
    .i_lane_err(i_lane_err), .o_sync_n(o_sync_n), .o_state(o_state),
    .o_lane_lock(o_lane_lock), .o_ilas_done(o_ilas_done), .o_link_up(o_link_up),
    .o_resync_cnt(o_resync_cnt)
  );

  initial begin
    dclk = 1'b0;
    forever #5 dclk = ~dclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic in_t mk_in(input logic le, input logic sr, input logic lm,
                                input logic [LANES-1:0] k, input logic [LANES-1:0] ila,
                                input logic [LANES-1:0] err);
    in_t r;
    r.link_en = le; r.sysref = sr; r.lmfc = lm; r.k = k; r.ila = ila; r.err = err;
    return r;
  endfunction

  function automatic vec_t mk(input in_t v, input logic [2:0] st, input logic sn,
                              input logic lu, input logic dn,
                              input logic [LANES-1:0] lk, input logic [7:0] rs);
    vec_t r;
    r.in = v; r.st = st; r.sync_n = sn; r.link_up = lu; r.done = dn; r.lock = lk; r.resync = rs;
    return r;
  endfunction

  task automatic apply(input in_t v);
    i_link_en        = v.link_en;
    i_sysref_done    = v.sysref;
    i_lmfc           = v.lmfc;
    i_lane_k_det     = v.k;
    i_lane_ila_start = v.ila;
    i_lane_err       = v.err;
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [2:0] st,
                           input logic sn, input logic lu, input logic dn,
                           input logic [LANES-1:0] lk, input logic [7:0] rs);
    n_checks++;
    if (o_state !== st || o_sync_n !== sn || o_link_up !== lu || o_ilas_done !== dn ||
        o_lane_lock !== lk || o_resync_cnt !== rs) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got state=%0d sync_n=%b link_up=%b ilas_done=%b lock=%b resync=%0d, expected state=%0d sync_n=%b link_up=%b ilas_done=%b lock=%b resync=%0d",
               tag, idx, $time, o_state, o_sync_n, o_link_up, o_ilas_done, o_lane_lock,
               o_resync_cnt, st, sn, lu, dn, lk, rs);
    end
  endtask

  // Behavioural reference: phases as integers, per-lane /K/ run lengths, error
  // tally per LMFC window; locks are derived from run lengths rather than stored.
  int  m_phase, m_run [LANES], m_wait_edges, m_ilas_edges, m_err_window, m_resync;
  bit  m_sysref, m_lmfc_prev;
  bit [LANES-1:0] m_seen;
  bit  e_sync, e_link, e_done;
  bit [LANES-1:0] e_lock;

  task automatic model_reset();
    m_phase = 0; m_wait_edges = 0; m_ilas_edges = 0; m_err_window = 0; m_resync = 0;
    m_sysref = 0; m_lmfc_prev = 0; m_seen = '0;
    for (int i = 0; i < LANES; i++) m_run[i] = 0;
  endtask

  task automatic model_step(input in_t v);
    bit edge_now, all_k, all_lock, fresh_cgs;
    int nxt, errs;
    edge_now = v.lmfc && !m_lmfc_prev;
    all_k    = (v.k == {LANES{1'b1}});
    all_lock = 1;
    for (int i = 0; i < LANES; i++) if (m_run[i] != K_THRESH) all_lock = 0;
    errs = (v.err != 0) ? 1 : 0;
    errs = edge_now ? errs : m_err_window + errs;
    nxt = m_phase;
    if (!v.link_en) nxt = 0;
    else if (m_phase == 0 && m_sysref) nxt = 1;
    else if (m_phase == 1 && all_lock) nxt = 2;
    else if (m_phase == 2 && !all_k) nxt = 1;
    else if (m_phase == 2 && edge_now && m_wait_edges + 1 >= SYNC_DELAY_LMFC) nxt = 3;
    else if (m_phase == 3 && m_seen == {LANES{1'b1}}) nxt = 4;
    else if (m_phase == 3 && edge_now && m_ilas_edges + 1 >= ILAS_TIMEOUT_LMFC) nxt = 1;
    else if (m_phase == 4 && errs >= ERR_THRESH) nxt = 1;

    e_done = (m_phase == 3 && nxt == 4);
    if ((m_phase == 3 || m_phase == 4) && nxt == 1 && m_resync < 255) m_resync++;
    fresh_cgs = (nxt == 1 && m_phase != 1);
    if (nxt == 0 || fresh_cgs) begin
      for (int i = 0; i < LANES; i++) m_run[i] = 0;
      m_seen = '0; m_wait_edges = 0; m_ilas_edges = 0; m_err_window = 0;
    end else if (m_phase == 1) begin
      for (int i = 0; i < LANES; i++)
        m_run[i] = v.k[i] ? ((m_run[i] + 1 > K_THRESH) ? K_THRESH : m_run[i] + 1) : 0;
    end else if (m_phase == 2) begin
      if (edge_now) m_wait_edges++;
    end else if (m_phase == 3) begin
      m_seen = m_seen | v.ila;
      if (edge_now) m_ilas_edges++;
    end else if (m_phase == 4) begin
      m_err_window = errs;
    end
    m_phase     = nxt;
    m_sysref    = v.link_en && (m_sysref || v.sysref);
    m_lmfc_prev = v.lmfc;
    e_sync = (nxt == 3 || nxt == 4);
    e_link = (nxt == 4);
    for (int i = 0; i < LANES; i++) e_lock[i] = (m_run[i] == K_THRESH);
  endtask

  vec_t tbl [NVEC];

  initial begin
    in_t v;
    int  lph;
    // bring-up, ILAS, error windows and link disable, cycle by cycle
    tbl[0]  = mk(mk_in(1, 1, 0, 2'b00, 2'b00, 2'b00), 0, 0, 0, 0, 2'b00, 0);
    tbl[1]  = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00), 1, 0, 0, 0, 2'b00, 0);
    tbl[2]  = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00), 1, 0, 0, 0, 2'b00, 0);
    tbl[3]  = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00), 1, 0, 0, 0, 2'b00, 0);
    tbl[4]  = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00), 1, 0, 0, 0, 2'b00, 0);
    tbl[5]  = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00), 1, 0, 0, 0, 2'b11, 0);
    tbl[6]  = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00), 2, 0, 0, 0, 2'b11, 0);
    tbl[7]  = mk(mk_in(1, 0, 1, 2'b11, 2'b00, 2'b00), 3, 1, 0, 0, 2'b11, 0);
    tbl[8]  = mk(mk_in(1, 0, 1, 2'b11, 2'b00, 2'b00), 3, 1, 0, 0, 2'b11, 0);
    tbl[9]  = mk(mk_in(1, 0, 0, 2'b11, 2'b11, 2'b00), 3, 1, 0, 0, 2'b11, 0);
    tbl[10] = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00), 4, 1, 1, 1, 2'b11, 0);
    tbl[11] = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00), 4, 1, 1, 0, 2'b11, 0);
    tbl[12] = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b01), 4, 1, 1, 0, 2'b11, 0);
    tbl[13] = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b10), 4, 1, 1, 0, 2'b11, 0);
    tbl[14] = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b11), 4, 1, 1, 0, 2'b11, 0);
    tbl[15] = mk(mk_in(1, 0, 1, 2'b11, 2'b00, 2'b00), 4, 1, 1, 0, 2'b11, 0);
    tbl[16] = mk(mk_in(1, 0, 1, 2'b11, 2'b00, 2'b01), 4, 1, 1, 0, 2'b11, 0);
    tbl[17] = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b01), 4, 1, 1, 0, 2'b11, 0);
    tbl[18] = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b01), 4, 1, 1, 0, 2'b11, 0);
    tbl[19] = mk(mk_in(1, 0, 1, 2'b11, 2'b00, 2'b01), 4, 1, 1, 0, 2'b11, 0);
    tbl[20] = mk(mk_in(1, 0, 1, 2'b11, 2'b00, 2'b01), 4, 1, 1, 0, 2'b11, 0);
    tbl[21] = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b10), 4, 1, 1, 0, 2'b11, 0);
    tbl[22] = mk(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b01), 1, 0, 0, 0, 2'b00, 1);
    tbl[23] = mk(mk_in(0, 0, 0, 2'b11, 2'b00, 2'b00), 0, 0, 0, 0, 2'b00, 1);

    rst_n = 1'b0;
    apply(mk_in(0, 0, 0, 2'b00, 2'b00, 2'b00));
    repeat (2) @(posedge dclk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 2'b00, 0);
    rst_n = 1'b1;

    for (int r = 0; r < NVEC; r++) begin
      apply(tbl[r].in);
      tick();
      check_all("table", r, tbl[r].st, tbl[r].sync_n, tbl[r].link_up, tbl[r].done,
                tbl[r].lock, tbl[r].resync);
    end

    // lane 1 loses /K/ at run length 3 and must restart its count
    apply(mk_in(1, 1, 0, 2'b11, 2'b00, 2'b00)); tick();
    check_all("cgs_drop", 0, 0, 0, 0, 0, 2'b00, 1);
    apply(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00)); tick();
    check_all("cgs_drop", 1, 1, 0, 0, 0, 2'b00, 1);
    repeat (3) tick();
    check_all("cgs_drop", 2, 1, 0, 0, 0, 2'b00, 1);
    apply(mk_in(1, 0, 0, 2'b01, 2'b00, 2'b00)); tick();
    check_all("cgs_drop", 3, 1, 0, 0, 0, 2'b01, 1);
    apply(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00)); repeat (3) tick();
    check_all("cgs_drop", 4, 1, 0, 0, 0, 2'b01, 1);
    tick();
    check_all("cgs_drop", 5, 1, 0, 0, 0, 2'b11, 1);
    tick();
    check_all("cgs_drop", 6, 2, 0, 0, 0, 2'b11, 1);

    // /K/ loss while waiting for the LMFC boundary returns to CGS, SYNC~ held low
    apply(mk_in(1, 0, 0, 2'b10, 2'b00, 2'b00)); tick();
    check_all("wait_kdrop", 0, 1, 0, 0, 0, 2'b00, 1);
    apply(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00)); repeat (4) tick();
    check_all("wait_kdrop", 1, 1, 0, 0, 0, 2'b11, 1);
    tick();
    check_all("wait_kdrop", 2, 2, 0, 0, 0, 2'b11, 1);
    apply(mk_in(1, 0, 1, 2'b11, 2'b00, 2'b00)); tick();
    check_all("wait_kdrop", 3, 3, 1, 0, 0, 2'b11, 1);

    // only lane 0 starts ILAS: second LMFC edge times out into CGS
    apply(mk_in(1, 0, 1, 2'b11, 2'b01, 2'b00)); tick();
    check_all("ilas_tmo", 0, 3, 1, 0, 0, 2'b11, 1);
    apply(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00)); tick();
    check_all("ilas_tmo", 1, 3, 1, 0, 0, 2'b11, 1);
    apply(mk_in(1, 0, 1, 2'b11, 2'b00, 2'b00)); tick();
    check_all("ilas_tmo", 2, 3, 1, 0, 0, 2'b11, 1);
    apply(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00)); tick();
    check_all("ilas_tmo", 3, 3, 1, 0, 0, 2'b11, 1);
    apply(mk_in(1, 0, 1, 2'b11, 2'b00, 2'b00)); tick();
    check_all("ilas_tmo", 4, 1, 0, 0, 0, 2'b00, 2);

    // reach DATA again, then assert reset between clock edges
    apply(mk_in(1, 0, 0, 2'b11, 2'b00, 2'b00)); repeat (4) tick();
    check_all("reset_mid_data", 0, 1, 0, 0, 0, 2'b11, 2);
    tick();
    check_all("reset_mid_data", 1, 2, 0, 0, 0, 2'b11, 2);
    apply(mk_in(1, 0, 1, 2'b11, 2'b00, 2'b00)); tick();
    check_all("reset_mid_data", 2, 3, 1, 0, 0, 2'b11, 2);
    apply(mk_in(1, 0, 1, 2'b11, 2'b11, 2'b00)); tick();
    check_all("reset_mid_data", 3, 3, 1, 0, 0, 2'b11, 2);
    apply(mk_in(1, 0, 1, 2'b11, 2'b00, 2'b00)); tick();
    check_all("reset_mid_data", 4, 4, 1, 1, 1, 2'b11, 2);
    #1 rst_n = 1'b0;
    #1;
    check_all("reset_mid_data", 5, 0, 0, 0, 0, 2'b00, 0);

    apply(mk_in(0, 0, 0, 2'b00, 2'b00, 2'b00));
    tick();
    rst_n = 1'b1;
    model_reset();
    lph = 0;

    for (int c = 0; c < RAND_CYCLES; c++) begin
      v.link_en = ($urandom_range(0, 299) != 0);
      v.sysref  = ($urandom_range(0, 15) == 0);
      lph = (lph + 1) % 8;
      if ($urandom_range(0, 63) == 0) lph = int'($urandom_range(0, 7));
      v.lmfc = (lph < 4);
      for (int i = 0; i < LANES; i++) begin
        v.k[i]   = ($urandom_range(0, 31) != 0);
        v.ila[i] = ($urandom_range(0, 5) == 0);
        v.err[i] = ($urandom_range(0, 11) == 0);
      end
      apply(v);
      model_step(v);
      tick();
      check_all("random", c, 3'(m_phase), e_sync, e_link, e_done, e_lock, 8'(m_resync));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
